minority_vote_scheduler: RTL and testbench

Round-robin scheduler sharing one minority-detector datapath (f = 1 iff at most one of three inputs is 1) among NREQ requesters. Each requester presents a 3-bit vote under a req/ack handshake. The block serialises the votes through the shared evaluator and returns each result with the requester ID over a valid/ready output. It sits between the vote sources and downstream consumers of the minority flag.

---
 rtl/minority_vote_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_minority_vote_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/minority_vote_scheduler.sv
// minority_vote_scheduler
// Round-robin scheduler that time-shares one minority evaluator
// (f = 1 when at most one of three vote bits is set) among NREQ requesters.
// A vote is captured under a req/ack handshake, evaluated one cycle later,
// and returned with the requester index over a valid/ready result port.
// Optional feature macro: MINORITY_STATS_EN enables the saturating min_count
// statistics counter; when undefined min_count is tied to zero.

module minority_vote_scheduler #(
   parameter int NREQ  = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req,
   input  logic [3*NREQ-1:0]   vote,
   output logic [NREQ-1:0]     ack,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [ID_W-1:0]     res_id,
   output logic                res_f,
   output logic                busy,
   output logic [CNT_W-1:0]    min_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   // Captured transaction and round-robin pointer
   logic [2:0]        vote_q;
   logic [ID_W-1:0]   id_q;
   logic [ID_W-1:0]   rr_ptr;

   // Arbitration results
   logic              win_found;
   logic [ID_W-1:0]   win_id;
   logic [2:0]        win_vote;
   logic [ID_W-1:0]   nxt_ptr;

   // Per-state control strobes
   logic              grant_en;
   logic              eval_en;
   logic              accept;
   logic [NREQ-1:0]   ack_nxt;

   // Minority of three: true when no pair of bits is set together,
   // i.e. popcount <= 1.
   function automatic logic minority(input logic [2:0] v);
      return ~((v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]));
   endfunction

   // Round-robin search: first requester at or above rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_id    = '0;
      win_vote  = 3'b000;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
            win_vote  = vote[3*idx +: 3];
         end
      end
   end

   // Pointer restarts just past the requester whose result was accepted.
   always_comb begin
      if (int'(id_q) >= NREQ - 1) begin
         nxt_ptr = '0;
      end else begin
         nxt_ptr = id_q + ID_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; req is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = EVAL;
         EVAL:    state_nxt = HOLD;
         HOLD:    if (res_valid && res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM output decode: strobes that drive the datapath registers.
   always_comb begin
      grant_en = 1'b0;
      eval_en  = 1'b0;
      accept   = 1'b0;
      busy     = 1'b0;
      ack_nxt  = '0;
      case (state)
         IDLE: begin
            grant_en = win_found;
         end
         EVAL: begin
            eval_en = 1'b1;
            busy    = 1'b1;
         end
         HOLD: begin
            accept = res_valid & res_ready;
            busy   = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
      for (int k = 0; k < NREQ; k++) begin
         ack_nxt[k] = grant_en && (int'(win_id) == k);
      end
   end

   // Datapath: capture on grant, evaluate in EVAL, release on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack       <= '0;
         vote_q    <= 3'b000;
         id_q      <= '0;
         rr_ptr    <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_f     <= 1'b0;
      end else begin
         ack <= ack_nxt;
         if (grant_en) begin
            vote_q <= win_vote;
            id_q   <= win_id;
         end
         if (eval_en) begin
            res_f     <= minority(vote_q);
            res_id    <= id_q;
            res_valid <= 1'b1;
         end else if (accept) begin
            res_valid <= 1'b0;
            rr_ptr    <= nxt_ptr;
         end
      end
   end

`ifdef MINORITY_STATS_EN
   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Count accepted results whose minority flag is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_count <= '0;
      end else if (accept && res_f) begin
         min_count <= sat_inc(min_count);
      end
   end
`else
   assign min_count = '0;
`endif

endmodule

// File: tb/tb_minority_vote_scheduler.sv
// Directed bench for minority_vote_scheduler: table-driven transactions
// plus hand-written latency, backpressure, reset and statistics sequences.

module tb_minority_vote_scheduler;

   localparam int NREQ  = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req;
   logic [3*NREQ-1:0]   vote;
   logic [NREQ-1:0]     ack;
   logic                res_valid;
   logic                res_ready;
   logic [ID_W-1:0]     res_id;
   logic                res_f;
   logic                busy;
   logic [CNT_W-1:0]    min_count;

   always #5 clk = ~clk;

   minority_vote_scheduler #(
      .NREQ  (NREQ),
      .ID_W  (ID_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .vote      (vote),
      .ack       (ack),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_f     (res_f),
      .busy      (busy),
      .min_count (min_count)
   );

   typedef struct {
      logic        pre_rst;
      logic [3:0]  r;
      logic [11:0] v;
      int          eid;
      logic        ef;
      logic        hold;
   } vec_t;

   vec_t vecs[13];
   int   checks  = 0;
   int   errors  = 0;
   int   exp_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_accept(input logic f);
      if (f) begin
`ifdef MINORITY_STATS_EN
         if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic run_txn(input string name, input logic [3:0] r, input logic [11:0] v,
                          input int eid, input logic ef, input logic hold);
      req       = r;
      vote      = v;
      res_ready = 1'b1;
      step();
      chk({name, ".ack"}, 32'(ack), 32'(1) << eid);
      chk({name, ".busy_grant"}, 32'(busy), 32'd1);
      if (!hold) req = '0;
      step();
      chk({name, ".ack_off"}, 32'(ack), 32'd0);
      chk({name, ".valid"}, 32'(res_valid), 32'd1);
      chk({name, ".id"}, 32'(res_id), 32'(eid));
      chk({name, ".f"}, 32'(res_f), 32'(ef));
      step();
      count_accept(ef);
      chk({name, ".valid_clr"}, 32'(res_valid), 32'd0);
      chk({name, ".busy_clr"}, 32'(busy), 32'd0);
      chk({name, ".cnt"}, 32'(min_count), 32'(exp_cnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tt_f;
      tt_f = 8'b0001_0111;
      for (int i = 0; i < 8; i++) begin
         vecs[i] = '{1'b0, 4'b0001, 12'(i), 0, tt_f[i], 1'b0};
      end
      vecs[8]  = '{1'b1, 4'hF, 12'b111_100_011_000, 0, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 4'hF, 12'b111_100_011_000, 1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 4'hF, 12'b111_100_011_000, 2, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 4'hF, 12'b111_100_011_000, 3, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 4'hF, 12'b111_100_011_000, 0, 1'b1, 1'b0};

      // Reset values
      rst_n = 1'b0; req = '0; vote = '0; res_ready = 1'b0;
      step();
      step();
      chk("rst.ack", 32'(ack), 32'd0);
      chk("rst.valid", 32'(res_valid), 32'd0);
      chk("rst.id", 32'(res_id), 32'd0);
      chk("rst.f", 32'(res_f), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.cnt", 32'(min_count), 32'd0);
      #2;
      rst_n = 1'b1;

      // Truth-table sweep and round-robin fairness
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].pre_rst) apply_reset();
         run_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].v, vecs[i].eid,
                 vecs[i].ef, vecs[i].hold);
      end

      // Latency: grant at N, result at N+1, earliest regrant at N+3
      req = 4'b0100; vote = 12'b000_110_000_000; res_ready = 1'b1;
      step();
      chk("lat.ack_n", 32'(ack), 32'h4);
      step();
      chk("lat.ack_n1", 32'(ack), 32'h0);
      chk("lat.valid_n1", 32'(res_valid), 32'd1);
      chk("lat.f", 32'(res_f), 32'd0);
      step();
      chk("lat.ack_n2", 32'(ack), 32'h0);
      chk("lat.valid_n2", 32'(res_valid), 32'd0);
      step();
      chk("lat.ack_n3", 32'(ack), 32'h4);
      req = '0;
      step();
      chk("lat.valid2", 32'(res_valid), 32'd1);
      step();

      // Backpressure with all requesters pending; rr_ptr is 3 here
      req = 4'hF; vote = 12'b001_000_000_000; res_ready = 1'b0;
      step();
      chk("bp.ack", 32'(ack), 32'h8);
      step();
      chk("bp.valid", 32'(res_valid), 32'd1);
      for (int c = 0; c < 10; c++) begin
         step();
         chk($sformatf("bp.valid%0d", c), 32'(res_valid), 32'd1);
         chk($sformatf("bp.id%0d", c), 32'(res_id), 32'd3);
         chk($sformatf("bp.f%0d", c), 32'(res_f), 32'd1);
         chk($sformatf("bp.ack%0d", c), 32'(ack), 32'd0);
         chk($sformatf("bp.busy%0d", c), 32'(busy), 32'd1);
      end
      res_ready = 1'b1;
      step();
      count_accept(1'b1);
      chk("bp.accept", 32'(res_valid), 32'd0);
      chk("bp.ack_idle", 32'(ack), 32'd0);
      step();
      chk("bp.wrap_ack", 32'(ack), 32'h1);
      req = '0;
      step();
      chk("bp.wrap_id", 32'(res_id), 32'd0);
      step();
      count_accept(1'b1);
      chk("bp.cnt", 32'(min_count), 32'(exp_cnt));

      // Reset while stalled in HOLD
      req = 4'b0010; vote = 12'b000_000_111_000; res_ready = 1'b0;
      step();
      chk("mr.ack", 32'(ack), 32'h2);
      step();
      chk("mr.valid", 32'(res_valid), 32'd1);
      rst_n = 1'b0;
      exp_cnt = 0;
      #1;
      chk("mr.ack0", 32'(ack), 32'd0);
      chk("mr.valid0", 32'(res_valid), 32'd0);
      chk("mr.id0", 32'(res_id), 32'd0);
      chk("mr.f0", 32'(res_f), 32'd0);
      chk("mr.busy0", 32'(busy), 32'd0);
      chk("mr.cnt0", 32'(min_count), 32'd0);
      req = 4'hF; vote = 12'b000_000_111_000; res_ready = 1'b1;
      #1;
      rst_n = 1'b1;
      step();
      chk("mr.regrant", 32'(ack), 32'h1);
      req = '0;
      step();
      chk("mr.f", 32'(res_f), 32'd1);
      step();
      count_accept(1'b1);

      // Statistics: five accepted minority results
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         run_txn($sformatf("st%0d", i), 4'b0001, 12'b0, 0, 1'b1, 1'b0);
      end
`ifdef MINORITY_STATS_EN
      chk("st.final", 32'(min_count), 32'd3);
`else
      chk("st.final", 32'(min_count), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
